// File: rtl/uart_tx_core.sv
// UART transmit engine: a small byte FIFO in front of a start/data/parity/stop
// serialiser whose framing and bit time are frozen per byte when it is popped.
module uart_tx_core #(
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_RATE   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_enable,
    input  logic [2:0]  uart_mode,
    input  logic [15:0] uart_rate,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        tx,
    output logic        uart_busy,
    output logic [1:0]  uart_error,
    output logic        update_ok,
    output logic [2:0]  dbg_state
);

    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE    = 1;
    localparam logic [15:0] MIN_RATE16 = 16'(MIN_RATE);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic        par_en_q, par_en_d;
    logic        two_stop_q, two_stop_d;
    logic [15:0] rate_q, rate_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_q, tx_d;
    logic [1:0]  err_q, err_d;

    logic        fifo_empty, fifo_full, push, pop, bit_done;
    logic [7:0]  pop_byte;

    // Stream handshake: a byte transfers on any rising edge where s_valid and
    // s_ready are both high; the source must hold s_data stable until then.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign s_ready    = rst_n && uart_enable && !fifo_full;
    assign push       = s_valid && s_ready;
    assign pop        = uart_enable && (state_q == S_IDLE) && !fifo_empty;
    assign bit_done   = (baud_cnt_q == rate_q - 16'd1);
    assign pop_byte   = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        shift_d    = shift_q;
        par_d      = par_q;
        par_en_d   = par_en_q;
        two_stop_d = two_stop_q;
        rate_d     = rate_q;
        baud_cnt_d = bit_done ? 16'd0 : baud_cnt_q + 16'd1;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        err_d      = 2'b00;

        if (state_q != S_IDLE && !uart_enable) begin
            state_d    = S_IDLE;
            tx_d       = 1'b1;
            err_d[0]   = 1'b1;
            baud_cnt_d = 16'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    baud_cnt_d = 16'd0;
                    tx_d       = 1'b1;
                    if (pop) begin
                        // Framing and bit time are frozen here for the whole frame.
                        shift_d    = pop_byte;
                        par_d      = (^pop_byte) ^ uart_mode[1];
                        par_en_d   = uart_mode[0];
                        two_stop_d = uart_mode[2];
                        rate_d     = uart_rate;
                        bit_cnt_d  = 3'd0;
                        if (uart_rate < MIN_RATE16) begin
                            err_d[1] = 1'b1;
                        end else begin
                            state_d = S_START;
                            tx_d    = 1'b0;
                        end
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        state_d = S_DATA;
                        tx_d    = shift_q[0];
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            if (par_en_q) begin
                                state_d = S_PARITY;
                                tx_d    = par_q;
                            end else begin
                                state_d = S_STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            shift_d   = shift_q >> 1;
                            tx_d      = shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_done) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end
                end
                S_STOP: begin
                    // bit_cnt marks the first of two stop bits already sent.
                    if (bit_done) begin
                        if (two_stop_q && bit_cnt_q == 3'd0) begin
                            bit_cnt_d = 3'd1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            rate_q     <= 16'd0;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            tx_q       <= 1'b1;
            err_q      <= 2'b00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            two_stop_q <= two_stop_d;
            rate_q     <= rate_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_data;
        end
    end

    assign tx         = tx_q;
    assign uart_error = err_q;
    assign update_ok  = (state_q == S_IDLE);
    assign uart_busy  = (state_q != S_IDLE) || !fifo_empty;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: a frame-level line model compared every cycle,
// directed frames with literal expectations, then randomized traffic.
module tb_uart_tx_core;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_enable;
    logic [2:0]  uart_mode;
    logic [15:0] uart_rate;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        tx;
    logic        uart_busy;
    logic [1:0]  uart_error;
    logic        update_ok;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    uart_tx_core #(.FIFO_DEPTH(DEPTH), .MIN_RATE(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_enable (uart_enable),
        .uart_mode   (uart_mode),
        .uart_rate   (uart_rate),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .tx          (tx),
        .uart_busy   (uart_busy),
        .uart_error  (uart_error),
        .update_ok   (update_ok),
        .dbg_state   (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t state=%0d)", name, act, exp, $time, dbg_state);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Line model: a frame is a list of bit values, each held for R cycles.
    logic [7:0] exp_q[$];
    bit         started = 1'b0;
    bit         m_in    = 1'b0;
    int         m_cyc, m_len, m_rate, m_nbits;
    logic       m_bits [0:11];
    logic       m_tx    = 1'b1;
    logic [1:0] m_err   = 2'b00;
    bit         do_push;
    logic [7:0] m_byte;

    always @(negedge clk) begin
        if (started) begin
            check("tx", 32'(tx), 32'(m_tx));
            check("uart_error", 32'(uart_error), 32'(m_err));
            check("uart_busy", 32'(uart_busy), 32'(m_in || exp_q.size() != 0));
            check("update_ok", 32'(update_ok), 32'(!m_in));
            check("s_ready", 32'(s_ready), 32'(rst_n && uart_enable && exp_q.size() < DEPTH));
        end
        if (!rst_n) begin
            exp_q.delete();
            m_in    = 1'b0;
            m_tx    = 1'b1;
            m_err   = 2'b00;
            started = 1'b1;
        end else begin
            do_push = s_valid && uart_enable && exp_q.size() < DEPTH;
            m_err   = 2'b00;
            if (m_in && !uart_enable) begin
                m_in  = 1'b0;
                m_tx  = 1'b1;
                m_err = 2'b01;
            end else if (m_in) begin
                m_cyc++;
                if (m_cyc == m_len) begin
                    m_in = 1'b0;
                    m_tx = 1'b1;
                end else begin
                    m_tx = m_bits[m_cyc / m_rate];
                end
            end else if (uart_enable && exp_q.size() > 0) begin
                m_byte = exp_q.pop_front();
                if (uart_rate < 16) begin
                    m_err = 2'b10;
                end else begin
                    m_bits[0] = 1'b0;
                    for (int i = 0; i < 8; i++) m_bits[1 + i] = m_byte[i];
                    m_nbits = 9;
                    if (uart_mode[0]) begin
                        m_bits[9] = uart_mode[1] ? ~^m_byte : ^m_byte;
                        m_nbits = 10;
                    end
                    m_bits[m_nbits] = 1'b1;
                    m_nbits++;
                    if (uart_mode[2]) begin
                        m_bits[m_nbits] = 1'b1;
                        m_nbits++;
                    end
                    m_rate = int'(uart_rate);
                    m_len  = m_nbits * m_rate;
                    m_cyc  = 0;
                    m_in   = 1'b1;
                    m_tx   = 1'b0;
                end
            end
            if (do_push) exp_q.push_back(s_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit ok;
        ok      = 1'b0;
        s_data  = b;
        s_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (s_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        s_valid = 1'b0;
        if (!ok) timeout("push_byte");
    endtask

    // Starts right after the push edge; samples mid-bit and counts busy cycles.
    task automatic frame_watch(input int len, input int r, output logic [11:0] cap, output int nlow);
        cap  = '0;
        nlow = 0;
        tick();
        for (int i = 0; i < len; i++) begin
            if (i % r == r / 2) cap = {cap[10:0], tx};
            if (!update_ok && uart_busy) nlow++;
            tick();
        end
    endtask

    function automatic logic [15:0] pick_rate();
        if ($urandom_range(0, 9) == 0) return 16'($urandom_range(0, 15));
        return 16'($urandom_range(16, 24));
    endfunction

    logic [11:0] cap;
    int          nlow;
    int          idx;
    bit          acc;

    initial begin
        rst_n       = 1'b0;
        uart_enable = 1'b1;
        uart_mode   = 3'b000;
        uart_rate   = 16'd16;
        s_valid     = 1'b0;
        s_data      = 8'h00;
        repeat (3) tick();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_error", 32'(uart_error), 32'd0);
        check("rst_busy", 32'(uart_busy), 32'd0);
        check("rst_update_ok", 32'(update_ok), 32'd1);
        rst_n = 1'b1;
        #1;
        check("post_rst_s_ready", 32'(s_ready), 32'd1);

        // Plain 8N1 frame of 0xA5
        push_byte(8'hA5);
        frame_watch(160, 16, cap, nlow);
        check("t1_bits", 32'(cap[9:0]), 32'(10'b0101001011));
        check("t1_busy_cycles", 32'(nlow), 32'd160);
        check("t1_end_update_ok", 32'(update_ok), 32'd1);
        check("t1_end_tx", 32'(tx), 32'd1);

        // Odd then even parity on 0x07
        uart_mode = 3'b011;
        push_byte(8'h07);
        frame_watch(176, 16, cap, nlow);
        check("t2_odd_bits", 32'(cap[10:0]), 32'(11'b01110000001));
        check("t2_odd_len", 32'(nlow), 32'd176);
        uart_mode = 3'b001;
        push_byte(8'h07);
        frame_watch(176, 16, cap, nlow);
        check("t2_even_bits", 32'(cap[10:0]), 32'(11'b01110000011));

        // Two stop bits, five bytes back-to-back
        uart_mode = 3'b100;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h30 + i));
        check("t3_full_s_ready", 32'(s_ready), 32'd0);
        check("t3_full_busy", 32'(uart_busy), 32'd1);
        nlow = 0;
        while (uart_busy && nlow < 2000) begin
            tick();
            nlow++;
        end
        if (uart_busy) timeout("t3_drain");
        check("t3_drain_cycles", 32'(nlow), 32'd881);

        // Illegal rate: byte dropped with an error pulse
        uart_mode = 3'b000;
        uart_rate = 16'd8;
        push_byte(8'h55);
        tick();
        check("t4_error", 32'(uart_error), 32'b10);
        check("t4_tx", 32'(tx), 32'd1);
        check("t4_busy", 32'(uart_busy), 32'd0);
        tick();
        check("t4_error_clear", 32'(uart_error), 32'd0);
        uart_rate = 16'd16;

        // Abort by dropping enable mid-frame
        push_byte(8'h3C);
        tick();
        repeat (50) tick();
        uart_enable = 1'b0;
        tick();
        check("t5_tx", 32'(tx), 32'd1);
        check("t5_error", 32'(uart_error), 32'b01);
        check("t5_update_ok", 32'(update_ok), 32'd1);
        tick();
        check("t5_error_clear", 32'(uart_error), 32'd0);
        uart_enable = 1'b1;
        tick();

        // Rate change mid-frame affects only the next frame
        push_byte(8'hFF);
        tick();
        idx = 0;
        repeat (5) begin
            tick();
            idx++;
        end
        uart_rate = 16'd32;
        push_byte(8'hFF);
        idx++;
        while (idx < 100) begin
            tick();
            idx++;
        end
        while (tx && idx < 400) begin
            tick();
            idx++;
        end
        check("t6_next_start", 32'(idx), 32'd161);
        nlow = 0;
        while (!tx && nlow < 100) begin
            tick();
            nlow++;
        end
        check("t6_start_len", 32'(nlow), 32'd32);
        nlow = 0;
        while (uart_busy && nlow < 1000) begin
            tick();
            nlow++;
        end
        if (uart_busy) timeout("t6_drain");

        // Randomized traffic, config churn, enable drops and resets
        for (int c = 0; c < 25000; c++) begin
            @(negedge clk);
            acc = s_valid && s_ready;
            tick();
            if (acc || !s_valid) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = 8'($urandom);
            end
            if ($urandom_range(0, 499) == 0) uart_rate = pick_rate();
            if ($urandom_range(0, 299) == 0) uart_mode = 3'($urandom);
            if (uart_enable && $urandom_range(0, 2999) == 0) uart_enable = 1'b0;
            else if (!uart_enable && $urandom_range(0, 19) == 0) uart_enable = 1'b1;
            if (rst_n && $urandom_range(0, 7999) == 0) rst_n = 1'b0;
            else if (!rst_n) rst_n = 1'b1;
        end
        s_valid = 1'b0;
        uart_enable = 1'b1;
        rst_n = 1'b1;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
